// File: rtl/serial_pkg.sv
// serial_pkg: shared state encodings and line levels for the serial transmitter.
// Parity support is enabled by defining SERIAL_TX_PARITY_EN.
package serial_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// baud_tick: bit-period counter, ticks on the last clock of each period.
// Macro SERIAL_TX_PARITY_EN does not affect this module.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: LSB-first framed transmitter, start bit 0, stop bit 1.
// Define SERIAL_TX_PARITY_EN to insert an even parity bit before stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              done,
  output logic              q
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [BW-1:0]     bitcnt;
  logic              tick;
  logic              accept;
`ifdef SERIAL_TX_PARITY_EN
  logic              par;
`endif

  assign accept  = (state == IDLE) && start && !rst;
  assign shifted = shreg >> 1;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state != IDLE),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      q      <= LINE_IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg  <= data_in;
            bitcnt <= '0;
            state  <= START;
            q      <= START_BIT;
            ready  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par    <= ^data_in;
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            q     <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shreg  <= shifted;
            bitcnt <= bitcnt + BW'(1);
            if (bitcnt == LAST_BIT) begin
              bitcnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state  <= PARITY;
              q      <= par;
`else
              state  <= STOP;
              q      <= STOP_BIT;
`endif
            end else begin
              q <= shifted[0];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            q     <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            q     <= LINE_IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          q     <= LINE_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// Parity frame step runs only when SERIAL_TX_PARITY_EN is defined.
module tb_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB  = DW + 3;
`else
  localparam int NB  = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] data_in;
  logic          ready;
  logic          done;
  logic          q;

  int checks = 0;
  int errors = 0;

  serial_tx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data_in(data_in),
    .ready  (ready),
    .done   (done),
    .q      (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the
  // negedge of the first IDLE cycle after the frame.
  task automatic run_frame(input logic [DW-1:0] d, input int poke);
    logic [DW-1:0] dd;
    logic          eb;
    int            k;
    dd = d;
    k  = 0;
    for (int i = 0; i < NB; i++) begin
      if (i == 0) eb = 1'b0;
      else if (i <= DW) eb = dd[i-1];
      else if (i == NB - 1) eb = 1'b1;
      else eb = ^dd;
      for (int c = 0; c < CPB; c++) begin
        check("q_bit", q, eb);
        check("ready_busy", ready, 1'b0);
        check("done_busy", done, 1'b0);
        if (k == poke) begin
          start   = 1'b1;
          data_in = 8'h3C;
        end else if (poke >= 0 && k == poke + 1) begin
          start = 1'b0;
        end
        k++;
        @(negedge clk);
      end
    end
    check("done_end", done, 1'b1);
    check("ready_end", ready, 1'b1);
    check("q_end", q, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_q", q, 1'b1);
      check("idle_ready", ready, 1'b1);
      check("idle_done", done, 1'b0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_q", q, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    idle_cycles(4);

    // Frame A5; data_in changes right after acceptance.
    start   = 1'b1;
    data_in = 8'hA5;
    @(negedge clk);
    start   = 1'b0;
    data_in = 8'h00;
    run_frame(8'hA5, -1);
    idle_cycles(3);

    // Busy start: 8'h3C poked mid-frame must be ignored.
    start   = 1'b1;
    data_in = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    run_frame(8'h5A, 13);
    idle_cycles(CPB * NB + 2);

    // Back-to-back with start held high.
    start   = 1'b1;
    data_in = 8'hFF;
    @(negedge clk);
    data_in = 8'h00;
    run_frame(8'hFF, -1);
    @(negedge clk);
    start = 1'b0;
    run_frame(8'h00, -1);
    idle_cycles(3);

    // Reset mid-frame during DATA, together with a start request.
    start   = 1'b1;
    data_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", ready, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midrst_q", q, 1'b1);
    check("midrst_ready", ready, 1'b1);
    check("midrst_done", done, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    idle_cycles(CPB * NB);

    start   = 1'b1;
    data_in = 8'h81;
    @(negedge clk);
    start = 1'b0;
    run_frame(8'h81, -1);
    idle_cycles(2);

`ifdef SERIAL_TX_PARITY_EN
    start   = 1'b1;
    data_in = 8'h07;
    @(negedge clk);
    start = 1'b0;
    run_frame(8'h07, -1);
    idle_cycles(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
